mips16_pipeline_core: RTL and testbench

- 16-bit, 5-stage (IF/ID/EX/MEM/WB) MIPS-style processor core.
- Contains its own instruction memory, data memory and 8x16 register file.
- Includes full forwarding, load-use stall detection and branch flush.
- Top-level compute block; the testbench preloads its memories and register file hierarchically and observes pc_out.

---
 rtl/mips16_pkg.sv | 40 ++++
 rtl/mips16_hazard_unit.sv | 47 ++++
 rtl/mips16_pipeline_core.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_mips16_pipeline_core.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips16_pkg.sv
// Shared constants and types for the 16-bit five-stage MIPS-style core.
package mips16_pkg;

    localparam int DATA_W = 16;
    localparam int REG_W  = 3;

    localparam logic [3:0] OP_RTYPE = 4'h0;
    localparam logic [3:0] OP_ADDI  = 4'h1;
    localparam logic [3:0] OP_LW    = 4'h2;
    localparam logic [3:0] OP_SW    = 4'h3;
    localparam logic [3:0] OP_BEQ   = 4'h4;
    localparam logic [3:0] OP_BNE   = 4'h5;

    localparam logic [2:0] FN_ADD = 3'd0;
    localparam logic [2:0] FN_SUB = 3'd1;
    localparam logic [2:0] FN_AND = 3'd2;
    localparam logic [2:0] FN_OR  = 3'd3;
    localparam logic [2:0] FN_SLT = 3'd4;
    localparam logic [2:0] FN_SLL = 3'd5;
    localparam logic [2:0] FN_SRL = 3'd6;

    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT,
        ALU_SLL,
        ALU_SRL
    } alu_op_e;

    function automatic logic [DATA_W-1:0] sext6(input logic [5:0] imm);
        return {{(DATA_W-6){imm[5]}}, imm};
    endfunction

endpackage

// File: rtl/mips16_hazard_unit.sv
// Combinational operand-forwarding selection and load-use stall detection.
module mips16_hazard_unit
    import mips16_pkg::*;
(
    input  logic [REG_W-1:0] id_ex_rs_i,
    input  logic [REG_W-1:0] id_ex_rt_i,
    input  logic             id_ex_valid_i,
    input  logic             id_ex_mem_read_i,
    input  logic [REG_W-1:0] if_id_rs_i,
    input  logic [REG_W-1:0] if_id_rt_i,
    input  logic             ex_mem_valid_i,
    input  logic             ex_mem_reg_write_i,
    input  logic [REG_W-1:0] ex_mem_reg_dst_i,
    input  logic             mem_wb_valid_i,
    input  logic             mem_wb_reg_write_i,
    input  logic [REG_W-1:0] mem_wb_reg_dst_i,
    output logic [1:0]       forward_a_o,
    output logic [1:0]       forward_b_o,
    output logic             load_use_hazard_o
);

    logic exMemCanFwd;
    logic memWbCanFwd;

    assign exMemCanFwd = ex_mem_valid_i && ex_mem_reg_write_i && (ex_mem_reg_dst_i != '0);
    assign memWbCanFwd = mem_wb_valid_i && mem_wb_reg_write_i && (mem_wb_reg_dst_i != '0);

    // The younger result in EX/MEM shadows an older one still in MEM/WB.
    always_comb begin
        forward_a_o = FWD_REG;
        forward_b_o = FWD_REG;
        if (exMemCanFwd && (ex_mem_reg_dst_i == id_ex_rs_i)) begin
            forward_a_o = FWD_EXMEM;
        end else if (memWbCanFwd && (mem_wb_reg_dst_i == id_ex_rs_i)) begin
            forward_a_o = FWD_MEMWB;
        end
        if (exMemCanFwd && (ex_mem_reg_dst_i == id_ex_rt_i)) begin
            forward_b_o = FWD_EXMEM;
        end else if (memWbCanFwd && (mem_wb_reg_dst_i == id_ex_rt_i)) begin
            forward_b_o = FWD_MEMWB;
        end
    end

    assign load_use_hazard_o = id_ex_valid_i && id_ex_mem_read_i &&
                               ((id_ex_rt_i == if_id_rs_i) || (id_ex_rt_i == if_id_rt_i));

endmodule

// File: rtl/mips16_pipeline_core.sv
// Five-stage 16-bit MIPS-style core with private instruction/data memories,
// full forwarding, load-use stalling and predict-not-taken branch flushing.
module mips16_pipeline_core
    import mips16_pkg::*;
#(
    parameter int IMEM_BYTES = 256,
    parameter int DMEM_BYTES = 512
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] pc_out
);

    localparam int IA_W = $clog2(IMEM_BYTES);
    localparam int DA_W = $clog2(DMEM_BYTES);

    logic [7:0]        instr_memory [IMEM_BYTES];
    logic [7:0]        data_memory  [DMEM_BYTES];
    logic [DATA_W-1:0] reg_file     [8];

    logic [DATA_W-1:0] pc_q, pc_d;

    logic              if_id_valid;
    logic [DATA_W-1:0] if_id_pc;
    logic [DATA_W-1:0] if_id_instr;

    logic              id_ex_valid;
    logic [DATA_W-1:0] id_ex_pc;
    logic [REG_W-1:0]  id_ex_rs, id_ex_rt, id_ex_rd;
    logic [DATA_W-1:0] id_ex_imm;
    alu_op_e           id_ex_alu_op;
    logic [DATA_W-1:0] id_ex_reg1, id_ex_reg2;
    logic              id_ex_reg_write, id_ex_mem_read, id_ex_mem_write;
    logic              id_ex_branch, id_ex_branch_ne, id_ex_alu_src, id_ex_use_rd;

    logic              ex_mem_valid;
    logic [DATA_W-1:0] ex_mem_alu_result;
    logic [DATA_W-1:0] ex_mem_store_data;
    logic [REG_W-1:0]  ex_mem_reg_dst;
    logic              ex_mem_reg_write, ex_mem_mem_read, ex_mem_mem_write;

    logic              mem_wb_valid;
    logic [DATA_W-1:0] mem_wb_data;
    logic [REG_W-1:0]  mem_wb_reg_dst;
    logic              mem_wb_reg_write;

    logic              load_use_hazard;
    logic              control_hazard;
    logic [1:0]        forward_a, forward_b;

    // Fetch: the two instruction bytes wrap independently within the memory.
    logic [IA_W-1:0]   fetchAddr0, fetchAddr1;
    logic [DATA_W-1:0] fetchWord;

    assign fetchAddr0 = pc_q[IA_W-1:0];
    assign fetchAddr1 = fetchAddr0 + IA_W'(1);
    assign fetchWord  = {instr_memory[fetchAddr0], instr_memory[fetchAddr1]};
    assign pc_out     = pc_q;

    logic [3:0]       idOpcode;
    logic [REG_W-1:0] idRs, idRt, idRd;
    logic [2:0]       idFunct;
    logic             idRegWrite, idMemRead, idMemWrite, idBranch, idBranchNe, idAluSrc, idUseRd;
    alu_op_e          idAluOp;

    assign idOpcode = if_id_instr[15:12];
    assign idRs     = if_id_instr[11:9];
    assign idRt     = if_id_instr[8:6];
    assign idRd     = if_id_instr[5:3];
    assign idFunct  = if_id_instr[2:0];

    always_comb begin
        idRegWrite = 1'b0;
        idMemRead  = 1'b0;
        idMemWrite = 1'b0;
        idBranch   = 1'b0;
        idBranchNe = 1'b0;
        idAluSrc   = 1'b0;
        idUseRd    = 1'b0;
        idAluOp    = ALU_ADD;
        case (idOpcode)
            OP_RTYPE: begin
                idUseRd    = 1'b1;
                idRegWrite = 1'b1;
                case (idFunct)
                    FN_ADD:  idAluOp = ALU_ADD;
                    FN_SUB:  idAluOp = ALU_SUB;
                    FN_AND:  idAluOp = ALU_AND;
                    FN_OR:   idAluOp = ALU_OR;
                    FN_SLT:  idAluOp = ALU_SLT;
                    FN_SLL:  idAluOp = ALU_SLL;
                    FN_SRL:  idAluOp = ALU_SRL;
                    default: idRegWrite = 1'b0;
                endcase
            end
            OP_ADDI: begin
                idRegWrite = 1'b1;
                idAluSrc   = 1'b1;
            end
            OP_LW: begin
                idRegWrite = 1'b1;
                idMemRead  = 1'b1;
                idAluSrc   = 1'b1;
            end
            OP_SW: begin
                idMemWrite = 1'b1;
                idAluSrc   = 1'b1;
            end
            OP_BEQ: idBranch = 1'b1;
            OP_BNE: begin
                idBranch   = 1'b1;
                idBranchNe = 1'b1;
            end
            default: ;
        endcase
    end

    // Register reads see the value being written back in the same cycle.
    logic              wbWrites;
    logic [DATA_W-1:0] idReg1, idReg2;

    assign wbWrites = mem_wb_valid && mem_wb_reg_write && (mem_wb_reg_dst != '0);
    assign idReg1 = (idRs == '0) ? '0 :
                    (wbWrites && (mem_wb_reg_dst == idRs)) ? mem_wb_data : reg_file[idRs];
    assign idReg2 = (idRt == '0) ? '0 :
                    (wbWrites && (mem_wb_reg_dst == idRt)) ? mem_wb_data : reg_file[idRt];

    mips16_hazard_unit u_hazard (
        .id_ex_rs_i         (id_ex_rs),
        .id_ex_rt_i         (id_ex_rt),
        .id_ex_valid_i      (id_ex_valid),
        .id_ex_mem_read_i   (id_ex_mem_read),
        .if_id_rs_i         (idRs),
        .if_id_rt_i         (idRt),
        .ex_mem_valid_i     (ex_mem_valid),
        .ex_mem_reg_write_i (ex_mem_reg_write),
        .ex_mem_reg_dst_i   (ex_mem_reg_dst),
        .mem_wb_valid_i     (mem_wb_valid),
        .mem_wb_reg_write_i (mem_wb_reg_write),
        .mem_wb_reg_dst_i   (mem_wb_reg_dst),
        .forward_a_o        (forward_a),
        .forward_b_o        (forward_b),
        .load_use_hazard_o  (load_use_hazard)
    );

    logic [DATA_W-1:0] exOpA, exOpB, exAluB, exAluResult, branchTarget;
    logic [REG_W-1:0]  exRegDst;

    always_comb begin
        case (forward_a)
            FWD_EXMEM: exOpA = ex_mem_alu_result;
            FWD_MEMWB: exOpA = mem_wb_data;
            default:   exOpA = id_ex_reg1;
        endcase
        case (forward_b)
            FWD_EXMEM: exOpB = ex_mem_alu_result;
            FWD_MEMWB: exOpB = mem_wb_data;
            default:   exOpB = id_ex_reg2;
        endcase
        exAluB = id_ex_alu_src ? id_ex_imm : exOpB;
        case (id_ex_alu_op)
            ALU_ADD: exAluResult = exOpA + exAluB;
            ALU_SUB: exAluResult = exOpA - exAluB;
            ALU_AND: exAluResult = exOpA & exAluB;
            ALU_OR:  exAluResult = exOpA | exAluB;
            ALU_SLT: exAluResult = {{(DATA_W-1){1'b0}}, ($signed(exOpA) < $signed(exAluB))};
            ALU_SLL: exAluResult = exOpA << exAluB[3:0];
            ALU_SRL: exAluResult = exOpA >> exAluB[3:0];
            default: exAluResult = '0;
        endcase
    end

    assign exRegDst       = id_ex_use_rd ? id_ex_rd : id_ex_rt;
    assign branchTarget   = id_ex_pc + 16'd2 + id_ex_imm;
    assign control_hazard = id_ex_valid && id_ex_branch && ((exOpA == exOpB) != id_ex_branch_ne);

    logic [DA_W-1:0]   memAddr0, memAddr1;
    logic [DATA_W-1:0] memWbDataD;

    assign memAddr0   = ex_mem_alu_result[DA_W-1:0];
    assign memAddr1   = memAddr0 + DA_W'(1);
    assign memWbDataD = ex_mem_mem_read ? {data_memory[memAddr0], data_memory[memAddr1]}
                                        : ex_mem_alu_result;

    // A taken branch outranks a load-use stall.
    always_comb begin
        pc_d = pc_q + 16'd2;
        if (control_hazard) begin
            pc_d = branchTarget;
        end else if (load_use_hazard) begin
            pc_d = pc_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q              <= '0;
            if_id_valid       <= 1'b0;
            if_id_pc          <= '0;
            if_id_instr       <= '0;
            id_ex_valid       <= 1'b0;
            id_ex_pc          <= '0;
            id_ex_rs          <= '0;
            id_ex_rt          <= '0;
            id_ex_rd          <= '0;
            id_ex_imm         <= '0;
            id_ex_alu_op      <= ALU_ADD;
            id_ex_reg1        <= '0;
            id_ex_reg2        <= '0;
            id_ex_reg_write   <= 1'b0;
            id_ex_mem_read    <= 1'b0;
            id_ex_mem_write   <= 1'b0;
            id_ex_branch      <= 1'b0;
            id_ex_branch_ne   <= 1'b0;
            id_ex_alu_src     <= 1'b0;
            id_ex_use_rd      <= 1'b0;
            ex_mem_valid      <= 1'b0;
            ex_mem_alu_result <= '0;
            ex_mem_store_data <= '0;
            ex_mem_reg_dst    <= '0;
            ex_mem_reg_write  <= 1'b0;
            ex_mem_mem_read   <= 1'b0;
            ex_mem_mem_write  <= 1'b0;
            mem_wb_valid      <= 1'b0;
            mem_wb_data       <= '0;
            mem_wb_reg_dst    <= '0;
            mem_wb_reg_write  <= 1'b0;
        end else begin
            pc_q <= pc_d;

            if (control_hazard) begin
                if_id_valid <= 1'b0;
            end else if (!load_use_hazard) begin
                if_id_valid <= 1'b1;
                if_id_pc    <= pc_q;
                if_id_instr <= fetchWord;
            end

            if (control_hazard || load_use_hazard) begin
                id_ex_valid     <= 1'b0;
                id_ex_reg_write <= 1'b0;
                id_ex_mem_read  <= 1'b0;
                id_ex_mem_write <= 1'b0;
                id_ex_branch    <= 1'b0;
            end else begin
                id_ex_valid     <= if_id_valid;
                id_ex_pc        <= if_id_pc;
                id_ex_rs        <= idRs;
                id_ex_rt        <= idRt;
                id_ex_rd        <= idRd;
                id_ex_imm       <= sext6(if_id_instr[5:0]);
                id_ex_alu_op    <= idAluOp;
                id_ex_reg1      <= idReg1;
                id_ex_reg2      <= idReg2;
                id_ex_reg_write <= idRegWrite;
                id_ex_mem_read  <= idMemRead;
                id_ex_mem_write <= idMemWrite;
                id_ex_branch    <= idBranch;
                id_ex_branch_ne <= idBranchNe;
                id_ex_alu_src   <= idAluSrc;
                id_ex_use_rd    <= idUseRd;
            end

            ex_mem_valid      <= id_ex_valid;
            ex_mem_alu_result <= exAluResult;
            ex_mem_store_data <= exOpB;
            ex_mem_reg_dst    <= exRegDst;
            ex_mem_reg_write  <= id_ex_reg_write;
            ex_mem_mem_read   <= id_ex_mem_read;
            ex_mem_mem_write  <= id_ex_mem_write;

            mem_wb_valid     <= ex_mem_valid;
            mem_wb_data      <= memWbDataD;
            mem_wb_reg_dst   <= ex_mem_reg_dst;
            mem_wb_reg_write <= ex_mem_reg_write;
        end
    end

    // Storage arrays are never reset; invalid stages simply never write them.
    always_ff @(posedge clk) begin
        if (ex_mem_valid && ex_mem_mem_write) begin
            data_memory[memAddr0] <= ex_mem_store_data[15:8];
            data_memory[memAddr1] <= ex_mem_store_data[7:0];
        end
        if (wbWrites) begin
            reg_file[mem_wb_reg_dst] <= mem_wb_data;
        end
    end

endmodule

// File: tb/tb_mips16_pipeline_core.sv
// Directed programs for the pipelined core with hand-computed register and memory results.
module tb_mips16_pipeline_core;

    logic        clk;
    logic        rst;
    logic [15:0] pc_out;

    int totalChecks = 0;
    int badChecks   = 0;
    int cycleIdx;
    int luCount;
    int chCount;
    logic [1:0]  fwdAHist [64];
    logic [1:0]  fwdBHist [64];
    logic [15:0] prog [32];
    int progLen;

    mips16_pipeline_core #(.IMEM_BYTES(256), .DMEM_BYTES(512)) dut (
        .clk    (clk),
        .rst    (rst),
        .pc_out (pc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] encR(input int rs, input int rt, input int rd, input int fn);
        return {4'h0, rs[2:0], rt[2:0], rd[2:0], fn[2:0]};
    endfunction

    function automatic logic [15:0] encI(input int op, input int rs, input int rt, input int imm);
        return {op[3:0], rs[2:0], rt[2:0], imm[5:0]};
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Holds the core in reset, clears memories and loads prog[0..progLen-1]; leaves rst low.
    task automatic applyStimulus(input bit clearRegs);
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int i = 0; i < 256; i++) dut.instr_memory[i] = 8'h00;
        for (int i = 0; i < 512; i++) dut.data_memory[i] = 8'h00;
        if (clearRegs) begin
            for (int i = 0; i < 8; i++) dut.reg_file[i] = 16'h0000;
        end
        for (int i = 0; i < progLen; i++) begin
            dut.instr_memory[2*i]   = prog[i][15:8];
            dut.instr_memory[2*i+1] = prog[i][7:0];
        end
        @(negedge clk);
        cycleIdx = 0;
        luCount  = 0;
        chCount  = 0;
    endtask

    task automatic runCycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            @(negedge clk);
            cycleIdx++;
            if (dut.load_use_hazard) luCount++;
            if (dut.control_hazard) chCount++;
            if (cycleIdx < 64) begin
                fwdAHist[cycleIdx] = dut.forward_a;
                fwdBHist[cycleIdx] = dut.forward_b;
            end
        end
    endtask

    initial begin
        rst = 1'b0;

        // Basic program: ALU, store, load, untaken branch
        prog[0] = encI(1, 0, 1, 5);
        prog[1] = encI(1, 0, 2, 3);
        prog[2] = encR(1, 2, 3, 0);
        prog[3] = encI(3, 0, 3, 4);
        prog[4] = encI(2, 0, 4, 4);
        prog[5] = encI(4, 1, 2, 2);
        prog[6] = encR(3, 2, 5, 1);
        progLen = 7;
        applyStimulus(1'b1);
        checkOutput("resetPc", pc_out, 16'h0000);
        checkOutput("resetValids", 16'({dut.if_id_valid, dut.id_ex_valid, dut.ex_mem_valid, dut.mem_wb_valid}), 16'h0000);
        checkOutput("resetHazards", 16'({dut.load_use_hazard, dut.control_hazard, dut.forward_a, dut.forward_b}), 16'h0000);
        rst = 1'b1;
        runCycles(1);
        checkOutput("pcFirstFetch", pc_out, 16'h0002);
        runCycles(19);
        checkOutput("t1 R1", dut.reg_file[1], 16'd5);
        checkOutput("t1 R2", dut.reg_file[2], 16'd3);
        checkOutput("t1 R3", dut.reg_file[3], 16'd8);
        checkOutput("t1 R4", dut.reg_file[4], 16'd8);
        checkOutput("t1 R5", dut.reg_file[5], 16'd5);
        checkOutput("t1 mem4", 16'(dut.data_memory[4]), 16'h0000);
        checkOutput("t1 mem5", 16'(dut.data_memory[5]), 16'h0008);
        checkOutput("t1 noBranch", 16'(chCount), 16'd0);

        // Back-to-back dependencies via forwarding
        prog[0] = encI(1, 0, 1, 10);
        prog[1] = encR(1, 1, 2, 0);
        prog[2] = encR(2, 1, 3, 0);
        progLen = 3;
        applyStimulus(1'b1);
        rst = 1'b1;
        runCycles(20);
        checkOutput("t2 R1", dut.reg_file[1], 16'd10);
        checkOutput("t2 R2", dut.reg_file[2], 16'd20);
        checkOutput("t2 R3", dut.reg_file[3], 16'd30);
        checkOutput("t2 fwdA c3", 16'(fwdAHist[3]), 16'h0002);
        checkOutput("t2 fwdB c3", 16'(fwdBHist[3]), 16'h0002);
        checkOutput("t2 fwdA c4", 16'(fwdAHist[4]), 16'h0002);
        checkOutput("t2 fwdB c4", 16'(fwdBHist[4]), 16'h0001);
        checkOutput("t2 fwdA c5", 16'(fwdAHist[5]), 16'h0000);

        // Taken beq skips one instruction
        prog[0] = encI(1, 0, 1, 1);
        prog[1] = encI(1, 0, 2, 1);
        prog[2] = encI(4, 1, 2, 2);
        prog[3] = encI(1, 0, 3, 5);
        prog[4] = encI(1, 0, 4, 10);
        progLen = 5;
        applyStimulus(1'b1);
        rst = 1'b1;
        runCycles(20);
        checkOutput("t3 R3", dut.reg_file[3], 16'd0);
        checkOutput("t3 R4", dut.reg_file[4], 16'd10);
        checkOutput("t3 ctrlHazard", 16'(chCount), 16'd1);

        // Load-use stall
        prog[0] = encI(2, 0, 1, 4);
        prog[1] = encR(1, 1, 2, 0);
        prog[2] = encR(2, 1, 3, 1);
        progLen = 3;
        applyStimulus(1'b1);
        dut.data_memory[4] = 8'h00;
        dut.data_memory[5] = 8'h0A;
        rst = 1'b1;
        runCycles(20);
        checkOutput("t4 R1", dut.reg_file[1], 16'd10);
        checkOutput("t4 R2", dut.reg_file[2], 16'd20);
        checkOutput("t4 R3", dut.reg_file[3], 16'd10);
        checkOutput("t4 loadUse", 16'(luCount), 16'd1);

        // Register file preloaded while running, then survives reset
        dut.reg_file[2] = 16'd10;
        dut.reg_file[3] = 16'd5;
        prog[0] = encR(2, 3, 1, 0);
        prog[1] = encR(1, 2, 4, 1);
        prog[2] = encR(3, 4, 5, 2);
        prog[3] = encR(1, 5, 6, 3);
        progLen = 4;
        applyStimulus(1'b0);
        rst = 1'b1;
        runCycles(20);
        checkOutput("t5 R1", dut.reg_file[1], 16'd15);
        checkOutput("t5 R4", dut.reg_file[4], 16'd5);
        checkOutput("t5 R5", dut.reg_file[5], 16'd5);
        checkOutput("t5 R6", dut.reg_file[6], 16'd15);

        // Taken bne, preceded by an aborted run cut short by reset
        prog[0] = encI(1, 0, 1, 5);
        prog[1] = encI(1, 0, 2, 3);
        prog[2] = encI(5, 1, 2, 2);
        prog[3] = encR(1, 2, 3, 0);
        prog[4] = encR(1, 2, 4, 1);
        progLen = 5;
        applyStimulus(1'b1);
        rst = 1'b1;
        runCycles(3);
        rst = 1'b0;
        #1;
        checkOutput("t6 midResetPc", pc_out, 16'h0000);
        checkOutput("t6 midResetValids", 16'({dut.if_id_valid, dut.id_ex_valid, dut.ex_mem_valid, dut.mem_wb_valid}), 16'h0000);
        repeat (4) @(negedge clk);
        checkOutput("t6 abortedR1", dut.reg_file[1], 16'd0);
        checkOutput("t6 abortedR2", dut.reg_file[2], 16'd0);
        rst = 1'b1;
        cycleIdx = 0;
        chCount  = 0;
        runCycles(20);
        checkOutput("t6 R1", dut.reg_file[1], 16'd5);
        checkOutput("t6 R3", dut.reg_file[3], 16'd0);
        checkOutput("t6 R4", dut.reg_file[4], 16'd2);
        checkOutput("t6 ctrlHazard", 16'(chCount), 16'd1);

        // slt/sll/srl, data address wrap, funct 111 NOP
        prog[0] = encI(1, 0, 1, -3);
        prog[1] = encI(1, 0, 2, 2);
        prog[2] = encR(1, 2, 3, 4);
        prog[3] = encR(2, 2, 4, 5);
        prog[4] = encR(1, 2, 5, 6);
        prog[5] = encI(3, 0, 5, -1);
        prog[6] = encI(2, 0, 6, -1);
        prog[7] = encR(1, 2, 7, 7);
        progLen = 8;
        applyStimulus(1'b1);
        dut.reg_file[7] = 16'h5555;
        rst = 1'b1;
        runCycles(20);
        checkOutput("t7 slt", dut.reg_file[3], 16'h0001);
        checkOutput("t7 sll", dut.reg_file[4], 16'h0008);
        checkOutput("t7 srl", dut.reg_file[5], 16'h3FFF);
        checkOutput("t7 mem511", 16'(dut.data_memory[511]), 16'h003F);
        checkOutput("t7 mem0", 16'(dut.data_memory[0]), 16'h00FF);
        checkOutput("t7 lwWrap", dut.reg_file[6], 16'h3FFF);
        checkOutput("t7 nopFunct", dut.reg_file[7], 16'h5555);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
